// File: rtl/jtag_tap_controller_pkg.sv
// Shared definitions for the lpGBT CSM JTAG TAP: state encodings,
// data-register selection and default opcodes.
package jtag_tap_controller_pkg;

    typedef enum logic [3:0] {
        STATE_EX2_DR  = 4'h0,
        STATE_EX1_DR  = 4'h1,
        STATE_SH_DR   = 4'h2,
        STATE_PAU_DR  = 4'h3,
        STATE_SEL_IR  = 4'h4,
        STATE_UPD_DR  = 4'h5,
        STATE_CAP_DR  = 4'h6,
        STATE_SEL_DR  = 4'h7,
        STATE_EX2_IR  = 4'h8,
        STATE_EX1_IR  = 4'h9,
        STATE_SH_IR   = 4'hA,
        STATE_PAU_IR  = 4'hB,
        STATE_RTI     = 4'hC,
        STATE_UPD_IR  = 4'hD,
        STATE_CAP_IR  = 4'hE,
        STATE_TLR     = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_e;

    // Low bits loaded into the IR shift register in Capture-IR; upper bits are zero.
    localparam logic [1:0]  IR_CAPTURE_LSBS      = 2'b01;
    localparam logic [31:0] DEFAULT_IDCODE_VALUE = 32'h1000_0001;
    localparam logic [3:0]  DEFAULT_IDCODE_INST  = 4'b0001;
    localparam logic [3:0]  DEFAULT_USER_INST    = 4'b0010;

endpackage

// File: rtl/jtag_tap_fsm_n.sv
// 16-state IEEE 1149.1 TAP state tracker with active-low asynchronous reset.
module jtag_tap_fsm_n
    import jtag_tap_controller_pkg::*;
(
    input  logic       tck,
    input  logic       rst_n,
    input  logic       tms,
    output logic [3:0] state
);

    tap_state_e state_q, state_d;

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = STATE_TLR;
        case (state_q)
            STATE_TLR:    state_d = tms ? STATE_TLR    : STATE_RTI;
            STATE_RTI:    state_d = tms ? STATE_SEL_DR : STATE_RTI;
            STATE_SEL_DR: state_d = tms ? STATE_SEL_IR : STATE_CAP_DR;
            STATE_CAP_DR: state_d = tms ? STATE_EX1_DR : STATE_SH_DR;
            STATE_SH_DR:  state_d = tms ? STATE_EX1_DR : STATE_SH_DR;
            STATE_EX1_DR: state_d = tms ? STATE_UPD_DR : STATE_PAU_DR;
            STATE_PAU_DR: state_d = tms ? STATE_EX2_DR : STATE_PAU_DR;
            STATE_EX2_DR: state_d = tms ? STATE_UPD_DR : STATE_SH_DR;
            STATE_UPD_DR: state_d = tms ? STATE_SEL_DR : STATE_RTI;
            STATE_SEL_IR: state_d = tms ? STATE_TLR    : STATE_CAP_IR;
            STATE_CAP_IR: state_d = tms ? STATE_EX1_IR : STATE_SH_IR;
            STATE_SH_IR:  state_d = tms ? STATE_EX1_IR : STATE_SH_IR;
            STATE_EX1_IR: state_d = tms ? STATE_UPD_IR : STATE_PAU_IR;
            STATE_PAU_IR: state_d = tms ? STATE_EX2_IR : STATE_PAU_IR;
            STATE_EX2_IR: state_d = tms ? STATE_UPD_IR : STATE_SH_IR;
            STATE_UPD_IR: state_d = tms ? STATE_SEL_DR : STATE_RTI;
            default:      state_d = STATE_TLR;
        endcase
    end

    always_comb begin
        state = state_q;
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: IR, BYPASS, IDCODE and one user DR with
// parallel capture/update towards the chip-configuration banks.
module jtag_tap_controller
    import jtag_tap_controller_pkg::*;
#(
    parameter int unsigned             IR_WIDTH     = 4,
    parameter int unsigned             DR_WIDTH     = 32,
    parameter logic [31:0]             IDCODE_VALUE = DEFAULT_IDCODE_VALUE,
    parameter logic [IR_WIDTH-1:0]     IDCODE_INST  = IR_WIDTH'(DEFAULT_IDCODE_INST),
    parameter logic [IR_WIDTH-1:0]     USER_INST    = IR_WIDTH'(DEFAULT_USER_INST),
    parameter logic [IR_WIDTH-1:0]     BYPASS_INST  = '1
) (
    input  logic                tck,
    input  logic                rst_n,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic [3:0]          state,
    output logic [IR_WIDTH-1:0] ir,
    input  logic [DR_WIDTH-1:0] dr_capture_data,
    output logic [DR_WIDTH-1:0] dr_update_data,
    output logic                dr_update
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);

    logic [3:0]          state_w;
    tap_state_e          cur;
    dr_sel_e             dr_sel;
    logic                dr_lsb;

    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic                bypass_q;
    logic [31:0]         idcode_q;
    logic [DR_WIDTH-1:0] user_q;
    logic [DR_WIDTH-1:0] dr_update_data_q;
    logic                dr_update_q;
    logic                tdo_q;
    logic                tdo_en_q;

    jtag_tap_fsm_n u_fsm (
        .tck   (tck),
        .rst_n (rst_n),
        .tms   (tms),
        .state (state_w)
    );

    assign cur = tap_state_e'(state_w);

    // BYPASS wins if opcodes ever collide; undefined opcodes also fall to bypass.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == BYPASS_INST) begin
            dr_sel = DR_BYPASS;
        end else if (ir_q == IDCODE_INST) begin
            dr_sel = DR_IDCODE;
        end else if (ir_q == USER_INST) begin
            dr_sel = DR_USER;
        end
    end

    always_comb begin
        dr_lsb = bypass_q;
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_q[0];
            DR_USER:   dr_lsb = user_q[0];
            default:   dr_lsb = bypass_q;
        endcase
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            ir_q             <= IDCODE_INST;
            ir_shift_q       <= '0;
            bypass_q         <= 1'b0;
            idcode_q         <= '0;
            user_q           <= '0;
            dr_update_data_q <= '0;
            dr_update_q      <= 1'b0;
        end else begin
            dr_update_q <= 1'b0;
            case (cur)
                STATE_CAP_IR: ir_shift_q <= IR_CAPTURE;
                STATE_SH_IR:  ir_shift_q <= {tdi, ir_shift_q[IR_WIDTH-1:1]};
                STATE_UPD_IR: ir_q       <= ir_shift_q;
                STATE_CAP_DR: begin
                    bypass_q <= 1'b0;
                    idcode_q <= IDCODE_VALUE;
                    user_q   <= dr_capture_data;
                end
                STATE_SH_DR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_q <= {tdi, idcode_q[31:1]};
                        // Shift form stays legal for a 1-bit user register.
                        DR_USER:   user_q   <= (user_q >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));
                        default:   bypass_q <= tdi;
                    endcase
                end
                STATE_UPD_DR: begin
                    if (ir_q == USER_INST) begin
                        dr_update_data_q <= user_q;
                        dr_update_q      <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Edges that land in Test-Logic-Reset restore the IDCODE instruction.
            if (tms && (cur == STATE_TLR || cur == STATE_SEL_IR)) begin
                ir_q <= IDCODE_INST;
            end
        end
    end

    always_ff @(negedge tck or negedge rst_n) begin
        if (!rst_n) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            case (cur)
                STATE_SH_IR: begin
                    tdo_q    <= ir_shift_q[0];
                    tdo_en_q <= 1'b1;
                end
                STATE_SH_DR: begin
                    tdo_q    <= dr_lsb;
                    tdo_en_q <= 1'b1;
                end
                default: begin
                    tdo_q    <= 1'b0;
                    tdo_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign state          = state_w;
    assign ir             = ir_q;
    assign tdo            = tdo_q;
    assign tdo_en         = tdo_en_q;
    assign dr_update_data = dr_update_data_q;
    assign dr_update      = dr_update_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: state-walk table, directed
// register sequences and a randomized run against a behavioural model.
module tb_jtag_tap_controller;

    logic        tck;
    logic        rst_n;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        tdo_en;
    logic [3:0]  state;
    logic [3:0]  ir;
    logic [31:0] dr_capture_data;
    logic [31:0] dr_update_data;
    logic        dr_update;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    jtag_tap_controller #(
        .IR_WIDTH     (4),
        .DR_WIDTH     (32),
        .IDCODE_VALUE (32'h1000_0001),
        .IDCODE_INST  (4'b0001),
        .USER_INST    (4'b0010),
        .BYPASS_INST  (4'b1111)
    ) dut (
        .tck             (tck),
        .rst_n           (rst_n),
        .tms             (tms),
        .tdi             (tdi),
        .tdo             (tdo),
        .tdo_en          (tdo_en),
        .state           (state),
        .ir              (ir),
        .dr_capture_data (dr_capture_data),
        .dr_update_data  (dr_update_data),
        .dr_update       (dr_update)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    always @(negedge tck) begin
        #1;
        if (tdo_en) en_cnt = en_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
        @(negedge tck);
        #1;
    endtask

    // From RTI: load an instruction, returning the bits seen on tdo; ends in RTI.
    task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
        cap = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cap[i] = tdo;
            step(i == 3, v[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI: shift n bits through the selected DR, then update; ends in RTI.
    task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // Behavioural model: spec-level transition table plus register contents.
    logic [3:0]  nxt0 [0:15];
    logic [3:0]  nxt1 [0:15];
    logic [3:0]  m_state, m_ir, m_irsh;
    logic        m_byp, m_upd, m_tdo, m_en;
    logic [31:0] m_id, m_user, m_upd_data;

    task automatic model_reset();
        m_state = 4'hF; m_ir = 4'h1; m_irsh = '0; m_byp = 1'b0; m_upd = 1'b0;
        m_tdo = 1'b0; m_en = 1'b0; m_id = '0; m_user = '0; m_upd_data = '0;
    endtask

    task automatic model_step(input logic t, input logic d, input logic [31:0] cap);
        logic [3:0] ns;
        m_upd = 1'b0;
        if (m_state == 4'hE) m_irsh = 4'b0001;
        if (m_state == 4'hA) m_irsh = (m_irsh >> 1) | (4'(d) << 3);
        if (m_state == 4'hD) m_ir = m_irsh;
        if (m_state == 4'h6) begin
            m_byp = 1'b0; m_id = 32'h1000_0001; m_user = cap;
        end
        if (m_state == 4'h2) begin
            if (m_ir == 4'h1)      m_id   = (m_id >> 1) | (32'(d) << 31);
            else if (m_ir == 4'h2) m_user = (m_user >> 1) | (32'(d) << 31);
            else                   m_byp  = d;
        end
        if (m_state == 4'h5 && m_ir == 4'h2) begin
            m_upd_data = m_user; m_upd = 1'b1;
        end
        ns = t ? nxt1[m_state] : nxt0[m_state];
        if (ns == 4'hF) m_ir = 4'h1;
        m_state = ns;
        m_en  = (m_state == 4'hA) || (m_state == 4'h2);
        m_tdo = 1'b0;
        if (m_state == 4'hA) m_tdo = m_irsh[0];
        if (m_state == 4'h2) m_tdo = (m_ir == 4'h1) ? m_id[0] : (m_ir == 4'h2) ? m_user[0] : m_byp;
    endtask

    typedef struct {
        logic       tms;
        logic [3:0] exp_state;
        logic       exp_en;
    } vec_t;

    vec_t tbl [0:25];

    initial begin
        logic [31:0] dout;
        logic [3:0]  cap;
        logic [3:0]  exp_seq [0:4];
        logic [31:0] cap_val;
        logic        rt, rd;

        nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                 4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
        nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                 4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
        tbl = '{
            '{1'b0, 4'hC, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b0, 4'h6, 1'b0}, '{1'b0, 4'h2, 1'b1},
            '{1'b1, 4'h1, 1'b0}, '{1'b0, 4'h3, 1'b0}, '{1'b1, 4'h0, 1'b0}, '{1'b0, 4'h2, 1'b1},
            '{1'b1, 4'h1, 1'b0}, '{1'b1, 4'h5, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b1, 4'h4, 1'b0},
            '{1'b0, 4'hE, 1'b0}, '{1'b0, 4'hA, 1'b1}, '{1'b1, 4'h9, 1'b0}, '{1'b0, 4'hB, 1'b0},
            '{1'b1, 4'h8, 1'b0}, '{1'b0, 4'hA, 1'b1}, '{1'b1, 4'h9, 1'b0}, '{1'b1, 4'hD, 1'b0},
            '{1'b1, 4'h7, 1'b0}, '{1'b1, 4'h4, 1'b0}, '{1'b1, 4'hF, 1'b0}, '{1'b1, 4'hF, 1'b0},
            '{1'b0, 4'hC, 1'b0}, '{1'b0, 4'hC, 1'b0}
        };

        rst_n = 1'b0; tms = 1'b1; tdi = 1'b0; dr_capture_data = '0;
        #12;
        check("reset_state", 32'(state), 32'hF);
        check("reset_ir", 32'(ir), 32'h1);
        check("reset_tdo_en", 32'(tdo_en), 32'h0);
        check("reset_upd", 32'(dr_update), 32'h0);
        @(negedge tck); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].tms, 1'b0);
            check($sformatf("walk_state_%0d", i), 32'(state), 32'(tbl[i].exp_state));
            check($sformatf("walk_en_%0d", i), 32'(tdo_en), 32'(tbl[i].exp_en));
        end
        check("walk_ir_after_tlr", 32'(ir), 32'h1);

        en_cnt = 0;
        shift_dr(32'h0, 32, dout);
        check("idcode_tdo", dout, 32'h1000_0001);
        check("idcode_en_count", 32'(en_cnt), 32'd32);
        check("idcode_no_upd", 32'(dr_update), 32'h0);

        load_ir(4'b0010, cap);
        check("ir_capture_tdo", 32'(cap), 32'b0001);
        check("ir_user", 32'(ir), 32'h2);

        dr_capture_data = 32'hA5A5_5A5A;
        shift_dr(32'hDEAD_BEEF, 32, dout);
        check("user_tdo", dout, 32'hA5A5_5A5A);
        check("user_upd_data", dr_update_data, 32'hDEAD_BEEF);
        check("user_upd_pulse", 32'(dr_update), 32'h1);
        step(1'b0, 1'b0);
        check("user_upd_pulse_end", 32'(dr_update), 32'h0);

        dr_capture_data = 32'h0F0F_3C3C;
        dout = '0;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            dout[i] = tdo;
            step(i == 9, cap_val_bit(32'h1234_5678, i));
        end
        check("pause_ex1", 32'(state), 32'h1);
        step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
        check("pause_state", 32'(state), 32'h3);
        check("pause_en", 32'(tdo_en), 32'h0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("pause_resume", 32'(state), 32'h2);
        for (int i = 10; i < 32; i++) begin
            dout[i] = tdo;
            step(i == 31, cap_val_bit(32'h1234_5678, i));
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("pause_tdo", dout, 32'h0F0F_3C3C);
        check("pause_upd_data", dr_update_data, 32'h1234_5678);
        check("pause_upd_pulse", 32'(dr_update), 32'h1);

        load_ir(4'b1111, cap);
        shift_dr(32'b1101, 4, dout);
        check("bypass_f_tdo", dout, 32'b1010);
        check("bypass_f_no_upd", 32'(dr_update), 32'h0);
        check("bypass_f_hold", dr_update_data, 32'h1234_5678);

        load_ir(4'b0111, cap);
        check("ir_undef", 32'(ir), 32'h7);
        shift_dr(32'b1101, 4, dout);
        check("bypass_7_tdo", dout, 32'b1010);
        check("bypass_7_no_upd", 32'(dr_update), 32'h0);

        load_ir(4'b0010, cap);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        check("tms5_start", 32'(state), 32'h2);
        exp_seq = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("tms5_seq_%0d", i), 32'(state), 32'(exp_seq[i]));
        end
        step(1'b1, 1'b0);
        check("tms5_hold", 32'(state), 32'hF);
        check("tms5_ir", 32'(ir), 32'h1);

        step(1'b0, 1'b0);
        load_ir(4'b0010, cap);
        dr_capture_data = 32'hFFFF_FFFF;
        shift_dr(32'h8000_0001, 32, dout);
        check("pre_reset_upd_data", dr_update_data, 32'h8000_0001);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        check("midshift_en", 32'(tdo_en), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(state), 32'hF);
        check("async_ir", 32'(ir), 32'h1);
        check("async_tdo_en", 32'(tdo_en), 32'h0);
        check("async_tdo", 32'(tdo), 32'h0);
        check("async_upd_data", dr_update_data, 32'h0);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        check("async_no_pulse", 32'(dr_update), 32'h0);
        check("async_stay_tlr", 32'(state), 32'hF);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            cap_val = $urandom;
            rt = ($urandom_range(0, 99) < 35);
            rd = 1'($urandom_range(0, 1));
            dr_capture_data = cap_val;
            step(rt, rd);
            model_step(rt, rd, cap_val);
            check("rnd_state", 32'(state), 32'(m_state));
            check("rnd_ir", 32'(ir), 32'(m_ir));
            check("rnd_upd_data", dr_update_data, m_upd_data);
            check("rnd_upd", 32'(dr_update), 32'(m_upd));
            check("rnd_tdo", 32'(tdo), 32'(m_tdo));
            check("rnd_tdo_en", 32'(tdo_en), 32'(m_en));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic cap_val_bit(input logic [31:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- Complete, parametrised IEEE 1149.1 TAP controller for the lpGBT CSM JTAG path: the 16-state TAP FSM plus instruction register, BYPASS, IDCODE and one user data register with a parallel capture/update interface.
- Generalises the bare state tracker: configurable IR/DR widths and opcodes, TDO generation, and update strobes to downstream configuration logic.
- Sits between the FMC-driven JTAG pins and the chip-configuration register banks.

Parameters:
- IR_WIDTH, 4, instruction register width (>=2)
- DR_WIDTH, 32, user data register width (>=1)
- IDCODE_VALUE, 32'h1000_0001, IDCODE capture value (bit 0 must be 1)
- IDCODE_INST, 4'b0001, IDCODE opcode (IR_WIDTH bits)
- USER_INST, 4'b0010, user DR opcode
- BYPASS_INST, all ones, BYPASS opcode

Ports:
- tck  in  1  test clock; all state on rising edge except TDO
- rst_n  in  1  asynchronous, active-low reset
- tms  in  1  test mode select
- tdi  in  1  test data in
- tdo  out  1  test data out, registered on falling tck
- tdo_en  out  1  high while TDO is driving valid shift data
- state  out  4  current TAP state encoding
- ir  out  IR_WIDTH  active instruction
- dr_capture_data  in  DR_WIDTH  parallel value loaded in Capture-DR when USER selected
- dr_update_data  out  DR_WIDTH  last value latched in Update-DR when USER selected
- dr_update  out  1  one-tck pulse after dr_update_data changes

Behaviour:
- State encoding (4 bits): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
- Transitions follow standard 1149.1. Any unused or illegal value goes to TLR.
- Five consecutive TMS=1 edges reach TLR from any state.
- Reset (rst_n low, asynchronous) sets these values:
  - state=TLR, ir=IDCODE_INST, tdo=0, tdo_en=0
  - dr_update_data=0, dr_update=0
  - shift registers cleared
- Entering TLR by TMS has the same effect on ir, but dr_update_data is held.
- IR path:
  - CapIR loads the IR shift register with {0..0,2'b01}.
  - ShIR shifts LSB first: tdi enters the MSB, the LSB goes to tdo.
  - On the rising edge while in UpdIR, ir <= shift register.
  - The IR shift register never changes ir outside UpdIR.
- DR selection by ir: IDCODE_INST selects the 32-bit IDCODE register; USER_INST selects the DR_WIDTH user register; BYPASS_INST or any undefined opcode selects the 1-bit bypass.
- CapDR loads:
  - bypass <= 0
  - IDCODE register <= IDCODE_VALUE
  - user register <= dr_capture_data (sampled on that edge)
- ShDR shifts only the selected register, LSB first, tdi into its MSB.
- Update (user register only): on the rising edge while in UpdDR with ir==USER_INST, dr_update_data <= user shift register and dr_update=1 for exactly the next tck cycle.
- Pause and Exit states hold all shift contents. Ex2 back to Shift resumes without recapture.
- TDO:
  - Registered on the falling edge of tck.
  - In ShIR/ShDR: tdo=LSB of the active shift register, tdo_en=1.
  - Otherwise tdo_en=0 and tdo=0.
- Reset asserted mid-shift aborts immediately. No dr_update pulse is produced and dr_update_data returns to 0.

Decomposition:
- Shared definitions package: the 16 state encodings (existing STATE_* names), IR capture pattern, default opcodes.
- Natural sub-module: jtag_tap_fsm_n. It holds only the 16-state next-state register with active-low asynchronous reset, instantiated once and exporting state. All registers, muxing and TDO logic stay in the top.

Test Plan:
- rst_n pulsed low mid-ShDR -> state=F, ir=0001, tdo_en=0, dr_update_data=0 immediately, without a tck edge.
- From state 2, five TMS=1 edges -> state sequence 1,5,7,4,F; then hold TMS=1 -> stays F.
- After reset: TMS 0,1,0,0 reaches ShDR; 32 shifts with TMS=1 on the last -> tdo bits equal 32'h1000_0001 LSB first; tdo_en high exactly 32 falling edges.
- Load IR=0010 via ShIR, reading back 01 capture on tdo (bits 1,0,0,0). With dr_capture_data=32'hA5A5_5A5A, shift in 32'hDEAD_BEEF:
  - tdo returns A5A5_5A5A.
  - After UpdDR: dr_update_data=DEAD_BEEF and dr_update is high one cycle.
- IR=1111 (and undefined 0111): shift pattern 1,0,1,1 -> tdo shows 0 then tdi delayed by one cycle; no dr_update.
- USER shift interrupted by Ex1DR→PauDR (3 cycles)→Ex2DR→ShDR -> data continuous, final dr_update_data identical to an uninterrupted shift.
